// File: rtl/bullet_controller.sv
// Bullet pool for one tank: spawns on fire edges, steps and bounces active
// bullets once per frame, retires them on lifetime expiry or collision report.
module bullet_controller #(
  parameter int NUM_BULLETS  = 5,
  parameter int BULLET_SPEED = 2,
  parameter int LIFETIME     = 600,
  parameter int COOLDOWN     = 15,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               frame_clk,
  input  logic                               fire,
  input  logic [9:0]                         Tank_X_Pos,
  input  logic [9:0]                         Tank_Y_Pos,
  input  logic [1:0]                         Tank_Dir_X,
  input  logic [1:0]                         Tank_Dir_Y,
  input  logic [NUM_BULLETS-1:0]             Bullet_Hit,
  output logic [10*NUM_BULLETS-1:0]          Bullet_X_Pos,
  output logic [10*NUM_BULLETS-1:0]          Bullet_Y_Pos,
  output logic [NUM_BULLETS-1:0]             isBulletActive,
  output logic                               fire_ack,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   bullets_free
);

  localparam int IDX_W  = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int FREE_W = $clog2(NUM_BULLETS + 1);

  localparam logic signed [10:0] SPEED = 11'(BULLET_SPEED);
  localparam logic signed [10:0] X_LO  = 11'(X_MIN);
  localparam logic signed [10:0] X_HI  = 11'(X_MAX);
  localparam logic signed [10:0] Y_LO  = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI  = 11'(Y_MAX);

  function automatic logic signed [10:0] dir_vel(input logic [1:0] d);
    case (d)
      2'b01:   return SPEED;
      2'b11:   return -SPEED;
      default: return '0;
    endcase
  endfunction

  logic fire_sync, fire_dly, fire_req;
  logic frame_sync, frame_dly, frame_tick;
  logic [9:0] cooldown;

  logic [NUM_BULLETS-1:0] active;
  logic [9:0]             pos_x [NUM_BULLETS];
  logic [9:0]             pos_y [NUM_BULLETS];
  logic signed [10:0]     vel_x [NUM_BULLETS];
  logic signed [10:0]     vel_y [NUM_BULLETS];
  logic [9:0]             life  [NUM_BULLETS];

  logic signed [10:0]     sum_x [NUM_BULLETS];
  logic signed [10:0]     sum_y [NUM_BULLETS];
  logic [9:0]             nxt_x [NUM_BULLETS];
  logic [9:0]             nxt_y [NUM_BULLETS];
  logic signed [10:0]     nvel_x [NUM_BULLETS];
  logic signed [10:0]     nvel_y [NUM_BULLETS];

  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic signed [10:0]     spawn_vx, spawn_vy;
  logic                   spawn_go;
  logic [FREE_W-1:0]      free_cnt;

  // Each axis bounces independently: an out-of-range step reverses V and holds.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      sum_x[i] = $signed({1'b0, pos_x[i]}) + vel_x[i];
      sum_y[i] = $signed({1'b0, pos_y[i]}) + vel_y[i];
      if (sum_x[i] < X_LO || sum_x[i] > X_HI) begin
        nxt_x[i]  = pos_x[i];
        nvel_x[i] = -vel_x[i];
      end else begin
        nxt_x[i]  = sum_x[i][9:0];
        nvel_x[i] = vel_x[i];
      end
      if (sum_y[i] < Y_LO || sum_y[i] > Y_HI) begin
        nxt_y[i]  = pos_y[i];
        nvel_y[i] = -vel_y[i];
      end else begin
        nxt_y[i]  = sum_y[i][9:0];
        nvel_y[i] = vel_y[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_vx = dir_vel(Tank_Dir_X);
  assign spawn_vy = dir_vel(Tank_Dir_Y);
  assign spawn_go = fire_req && (cooldown == '0) && free_found &&
                    ((spawn_vx != '0) || (spawn_vy != '0));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fire_sync  <= 1'b1;
      fire_dly   <= 1'b1;
      fire_req   <= 1'b0;
      frame_sync <= 1'b1;
      frame_dly  <= 1'b1;
      frame_tick <= 1'b0;
      cooldown   <= '0;
      fire_ack   <= 1'b0;
      active     <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        life[i]  <= '0;
      end
    end else begin
      fire_sync  <= fire;
      fire_dly   <= fire_sync;
      fire_req   <= fire_sync & ~fire_dly;
      frame_sync <= frame_clk;
      frame_dly  <= frame_sync;
      frame_tick <= frame_sync & ~frame_dly;
      fire_ack   <= spawn_go;

      if (spawn_go)
        cooldown <= 10'(COOLDOWN);
      else if (frame_tick && cooldown != '0)
        cooldown <= cooldown - 10'd1;

      // Hit beats spawn beats frame step; a just-spawned bullet does not move.
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (Bullet_Hit[i] && active[i]) begin
          active[i] <= 1'b0;
        end else if (spawn_go && free_idx == IDX_W'(i)) begin
          active[i] <= 1'b1;
          pos_x[i]  <= Tank_X_Pos;
          pos_y[i]  <= Tank_Y_Pos;
          vel_x[i]  <= spawn_vx;
          vel_y[i]  <= spawn_vy;
          life[i]   <= 10'(LIFETIME);
        end else if (frame_tick && active[i]) begin
          if (life[i] == 10'd1) begin
            active[i] <= 1'b0;
          end else begin
            life[i]  <= life[i] - 10'd1;
            pos_x[i] <= nxt_x[i];
            pos_y[i] <= nxt_y[i];
            vel_x[i] <= nvel_x[i];
            vel_y[i] <= nvel_y[i];
          end
        end
      end
    end
  end

  always_comb begin
    free_cnt = FREE_W'(NUM_BULLETS);
    for (int i = 0; i < NUM_BULLETS; i++)
      if (active[i]) free_cnt = free_cnt - FREE_W'(1);
  end

  always_comb begin
    Bullet_X_Pos = '0;
    Bullet_Y_Pos = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      Bullet_X_Pos[10*i +: 10] = pos_x[i];
      Bullet_Y_Pos[10*i +: 10] = pos_y[i];
    end
  end

  assign isBulletActive = active;
  assign bullets_free   = free_cnt;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed vector bench for bullet_controller, with a second instance
// built with a short lifetime for the expiry sequence.
module tb_bullet_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_clk = 1'b1;
  logic        fire = 1'b1;
  logic        fire_l = 1'b0;
  logic [9:0]  tank_x = '0, tank_y = '0;
  logic [1:0]  dir_x = '0, dir_y = '0;
  logic [4:0]  hit = '0;
  logic [4:0]  hit_l = '0;
  logic [49:0] bx, by, bx_l, by_l;
  logic [4:0]  act, act_l;
  logic        ack, ack_l;
  logic [2:0]  free, free_l;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bullet_controller dut (
    .Clk(clk), .Reset(reset_n), .frame_clk(frame_clk), .fire(fire),
    .Tank_X_Pos(tank_x), .Tank_Y_Pos(tank_y), .Tank_Dir_X(dir_x), .Tank_Dir_Y(dir_y),
    .Bullet_Hit(hit), .Bullet_X_Pos(bx), .Bullet_Y_Pos(by),
    .isBulletActive(act), .fire_ack(ack), .bullets_free(free)
  );

  bullet_controller #(.LIFETIME(4)) dut_life (
    .Clk(clk), .Reset(reset_n), .frame_clk(frame_clk), .fire(fire_l),
    .Tank_X_Pos(tank_x), .Tank_Y_Pos(tank_y), .Tank_Dir_X(dir_x), .Tank_Dir_Y(dir_y),
    .Bullet_Hit(hit_l), .Bullet_X_Pos(bx_l), .Bullet_Y_Pos(by_l),
    .isBulletActive(act_l), .fire_ack(ack_l), .bullets_free(free_l)
  );

  typedef struct {
    int tx, ty;
    logic [1:0] dx, dy;
    int ticks;
    int ack, act, ex, ey, free;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic int sx(input logic [49:0] v, input int i);
    return int'(v[10*i +: 10]);
  endfunction

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_tick();
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) frame_tick();
  endtask

  // Pulses fire (or the short-lifetime instance's fire) and counts ack cycles.
  task automatic fire_req(input bit life, output int acks);
    acks = 0;
    @(negedge clk);
    if (life) fire_l = 1'b1; else fire = 1'b1;
    @(negedge clk);
    fire_l = 1'b0;
    fire = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (life ? ack_l : ack) acks++;
    end
  endtask

  initial begin
    int acks;

    vecs[0]  = '{100, 200, 2'b01, 2'b00, 3, 1, 1, 106, 200, 4};
    vecs[1]  = '{300, 100, 2'b11, 2'b11, 2, 1, 1, 296,  96, 4};
    vecs[2]  = '{ 50,  50, 2'b00, 2'b01, 1, 1, 1,  50,  52, 4};
    vecs[3]  = '{ 10,  10, 2'b00, 2'b00, 2, 0, 0,   0,   0, 5};
    vecs[4]  = '{ 10,  10, 2'b10, 2'b00, 2, 0, 0,   0,   0, 5};
    vecs[5]  = '{  1,   5, 2'b11, 2'b00, 2, 1, 1,   3,   5, 4};
    vecs[6]  = '{ 20, 478, 2'b00, 2'b01, 2, 1, 1,  20, 476, 4};
    vecs[7]  = '{637, 477, 2'b01, 2'b01, 2, 1, 1, 639, 479, 4};
    vecs[8]  = '{638, 200, 2'b01, 2'b00, 1, 1, 1, 638, 200, 4};
    vecs[9]  = '{638, 200, 2'b01, 2'b00, 2, 1, 1, 636, 200, 4};
    vecs[10] = '{ 10,  10, 2'b10, 2'b01, 1, 1, 1,  10,  12, 4};
    vecs[11] = '{ 40,   1, 2'b00, 2'b11, 1, 1, 1,  40,   1, 4};

    // Reset with fire and frame_clk held high, then release and drop them.
    acks = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack) acks++;
    end
    fire = 1'b0;
    frame_clk = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("reset_ack", acks, 0);
    check("reset_active", int'(act), 0);
    check("reset_free", int'(free), 5);
    check("reset_x", (bx == '0) ? 0 : 1, 0);
    check("reset_y", (by == '0) ? 0 : 1, 0);

    for (int v = 0; v < 12; v++) begin
      do_reset();
      tank_x = 10'(vecs[v].tx);
      tank_y = 10'(vecs[v].ty);
      dir_x  = vecs[v].dx;
      dir_y  = vecs[v].dy;
      fire_req(1'b0, acks);
      check($sformatf("v%0d_ack", v), acks, vecs[v].ack);
      ticks(vecs[v].ticks);
      check($sformatf("v%0d_active", v), int'(act), vecs[v].act);
      check($sformatf("v%0d_x", v), sx(bx, 0), vecs[v].ex);
      check($sformatf("v%0d_y", v), sx(by, 0), vecs[v].ey);
      check($sformatf("v%0d_free", v), int'(free), vecs[v].free);
    end

    // Fill all slots, then a sixth request finds none free.
    do_reset();
    tank_x = 10'd100; tank_y = 10'd100; dir_x = 2'b01; dir_y = 2'b00;
    for (int k = 0; k < 6; k++) begin
      fire_req(1'b0, acks);
      check($sformatf("fill%0d_ack", k), acks, (k < 5) ? 1 : 0);
      check($sformatf("fill%0d_active", k), int'(act), (k < 5) ? ((1 << (k + 1)) - 1) : 31);
      ticks(16);
    end
    check("full_free", int'(free), 0);

    // Hit slot 2 on the same edge as a frame step.
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    @(negedge clk) hit = 5'b00100;
    @(negedge clk) hit = 5'b00000;
    @(negedge clk);
    check("hit_active", int'(act), 5'b11011);
    check("hit_x2_hold", sx(bx, 2), 228);
    check("hit_x3_moved", sx(bx, 3), 198);
    check("hit_free", int'(free), 1);

    fire_req(1'b0, acks);
    check("reuse_ack", acks, 1);
    check("reuse_active", int'(act), 31);
    check("reuse_x2", sx(bx, 2), 100);

    ticks(5);
    @(negedge clk) hit = 5'b00001;
    @(negedge clk) hit = 5'b00000;
    check("hit0_active", int'(act), 5'b11110);
    fire_req(1'b0, acks);
    check("cooldown_ack", acks, 0);
    check("cooldown_active", int'(act), 5'b11110);

    // Fire edge and frame edge together: spawn, no move, cooldown not decremented.
    do_reset();
    tank_x = 10'd200; tank_y = 10'd200; dir_x = 2'b01; dir_y = 2'b00;
    acks = 0;
    @(negedge clk) begin fire = 1'b1; frame_clk = 1'b1; end
    @(negedge clk) begin fire = 1'b0; frame_clk = 1'b0; end
    repeat (5) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("simul_ack", acks, 1);
    check("simul_x", sx(bx, 0), 200);
    ticks(14);
    fire_req(1'b0, acks);
    check("simul_cd14_ack", acks, 0);
    ticks(1);
    fire_req(1'b0, acks);
    check("simul_cd15_ack", acks, 1);
    check("simul_active", int'(act), 3);
    check("simul_x0", sx(bx, 0), 230);

    // Short-lifetime instance: alive for 3 steps, retired on the 4th.
    do_reset();
    tank_x = 10'd100; tank_y = 10'd200; dir_x = 2'b01; dir_y = 2'b00;
    fire_req(1'b1, acks);
    check("life_ack", acks, 1);
    check("life_active0", int'(act_l[0]), 1);
    for (int t = 1; t <= 3; t++) begin
      frame_tick();
      check($sformatf("life_active%0d", t), int'(act_l[0]), 1);
      check($sformatf("life_x%0d", t), sx(bx_l, 0), 100 + 2 * t);
    end
    frame_tick();
    check("life_expired", int'(act_l[0]), 0);
    check("life_x_hold", sx(bx_l, 0), 106);
    check("life_free", int'(free_l), 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bullet_controller.md
# bullet_controller

Owns and animates one tank's bullets: spawns a bullet at the tank centre on a fire request, steps every active bullet once per frame, bounces it off the playfield edges, and retires it on timeout or on a hit report. It is the producer side of the tank–bullet collision path: its position/active outputs feed the collision checkers, and their hit flags come back into `Bullet_Hit`.

## Interface
Parameters:
- NUM_BULLETS, 5, bullet slots per tank
- BULLET_SPEED, 2, pixels moved per frame per axis when that axis direction is non-zero
- LIFETIME, 600, frames a bullet lives (10 s at 60 Hz)
- COOLDOWN, 15, frames after a spawn during which fire is ignored
- X_MIN / X_MAX, 0 / 639, inclusive horizontal bounds
- Y_MIN / Y_MAX, 0 / 479, inclusive vertical bounds

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- frame_clk  in  1  frame strobe; each rising edge is one frame tick
- fire  in  1  fire button, level; each rising edge is one request
- Tank_X_Pos, Tank_Y_Pos  in  10  tank centre
- Tank_Dir_X, Tank_Dir_Y  in  2  two's-complement direction per axis: -1, 0, +1 (2'b10 is illegal and treated as 0)
- Bullet_Hit  in  NUM_BULLETS  per-slot hit report from collision logic
- Bullet_X_Pos, Bullet_Y_Pos  out  10*NUM_BULLETS  flattened; slot i at [10i+9:10i]
- isBulletActive  out  NUM_BULLETS  slot i occupied
- fire_ack  out  1  one-cycle pulse when a bullet spawns
- bullets_free  out  $clog2(NUM_BULLETS+1)  count of inactive slots

## Operation
- Input conditioning: `fire` and `frame_clk` each go through two flops (sync, delayed). Edge = sync & ~delayed. On reset both flops load 1, so an input already held high does not produce an edge.
- Per slot state: active, X, Y (10-bit), VX, VY (signed, ±BULLET_SPEED or 0), life counter (10-bit).
- Spawn: on a fire edge, a bullet spawns only if the cooldown is 0, at least one slot was inactive at the start of the cycle, and the direction is not (0,0). The lowest-index free slot is used. It loads X/Y from the tank, VX/VY from direction×BULLET_SPEED and life from LIFETIME. Cooldown loads COOLDOWN and fire_ack pulses. A rejected request is dropped, never queued.
- Frame tick: the cooldown decrements if non-zero. Each active slot not spawned and not hit this cycle is updated:
  - If life == 1, the slot goes inactive and the position holds.
  - Otherwise life decrements and each axis is updated independently. next = pos + V, computed 11-bit signed. If next < MIN or next > MAX, V negates and pos holds (bounce). Otherwise pos = next.
- Hit: Bullet_Hit[i] with slot i active deactivates it on the next edge. A hit takes priority over the frame update. Hits on inactive slots are ignored. A slot freed by a hit is not eligible for a spawn in the same cycle.
- Inactive slots hold their last position. Consumers must gate with isBulletActive.
- Simultaneous fire edge and frame tick: the spawn happens, the new bullet does not move on that tick, and the cooldown loads COOLDOWN (no decrement that cycle).
- bullets_free = NUM_BULLETS − popcount(isBulletActive), combinational from registers.

## Timing
- Reset (Reset low at an edge): isBulletActive = 0, all positions = 0, velocities = 0, life = 0, cooldown = 0, fire_ack = 0, bullets_free = NUM_BULLETS.
- Fire latency: the first Clk edge sampling fire = 1 is edge n. At edge n+2, isBulletActive[k] is 1 and fire_ack is high for the following cycle.
- Frame latency: a frame_clk rise sampled at edge n causes the position update at edge n+2.
- A hit sampled at edge n clears the active bit at edge n (registered; visible in the next cycle).
- Reset asserted mid-flight clears everything on that edge; pending edges are lost.

## Test plan
- Reset with fire and frame_clk held high, then release → no spawn, no move; bullets_free = 5, all outputs 0.
- Tank (100,200), dir (+1,0), one fire pulse → slot 0 active at (100,200), fire_ack one cycle; after 3 ticks X = 106, Y = 200.
- Bounce: spawn at X = 638, dir (+1,0), speed 2 → first tick X holds at 638 and VX = −2; next tick X = 636.
- Cooldown and full: 6 fire edges spaced ≥16 ticks apart → slots 0–4 fill and the 6th gets no ack. Then a fire edge 5 ticks after a spawn with a free slot available → rejected.
- Hit on slot 2 during a frame tick → slot 2 inactive, its position unchanged; the next fire edge (cooldown 0) reuses slot 2.
- Lifetime: LIFETIME = 4 for this test, spawn → active through 3 ticks, inactive on the 4th tick with the position from the 3rd tick.
